// File: rtl/cprv_ram_pkg.sv
// Shared definitions for the single-port pipelined RAM and its response FIFO.
// The response struct carries the widest supported word; the top zero-extends
// narrower words into it. Constant-zero upper bits are pruned by synthesis.
package cprv_ram_pkg;

  // Deepest read pipeline the RAM supports (RD_LATENCY is clamped to this).
  localparam int RD_LATENCY_MAX = 4;

  // Widest data word carried by a response (DATA_WIDTH must not exceed it).
  localparam int RESP_DATA_W = 512;

  // One response as it travels through the read pipeline and response FIFO.
  typedef struct packed {
    logic [RESP_DATA_W-1:0] rdata;
    logic                   resp_we;
  } resp_t;

  // Pointer width for a circular buffer of the given depth (at least 1 bit).
  function automatic int unsigned cprv_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cprv_resp_fifo.sv
// Response FIFO: circular buffer with valid/ready on both sides.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and data is held while valid & ~ready.
// out_data reads as zero whenever the FIFO is empty.
module cprv_resp_fifo
  import cprv_ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = cprv_ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Advance a pointer by one entry, wrapping at DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // A full FIFO still accepts a push in the same cycle as a pop.
  assign in_ready  = (count != CW'(DEPTH)) | out_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/cprv_ram_1p_pipe.sv
// Single-port RAM with a fixed-latency read pipeline and a credit-controlled
// response FIFO. Each accepted request (read or write) yields one response,
// in order. Writes are read-first: their response carries the old word.
//
// Handshake: a request transfers on a rising edge where valid_i & ready_o;
// a response transfers on a rising edge where valid_o & ready_i. ready_o is
// a function of registered state only, valid_o never depends on ready_i, and
// rdata/resp_we hold steady while valid_o & ~ready_i.
//
// Optional feature: define CPRV_RAM_WSTRB_EN to honour per-byte write
// strobes; without it wstrb is ignored and writes replace the full word.
module cprv_ram_1p_pipe
  import cprv_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1,
  parameter int OUT_DEPTH  = RD_LATENCY + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    w_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    resp_we
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LAT   = (RD_LATENCY < 1) ? 1 :
                         (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;
  localparam int OCC_W = $clog2(OUT_DEPTH + 1);

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wmask;
  logic                  accept;
  logic                  pop;
  logic [OCC_W-1:0]      occ;
  resp_t                 acc_resp;
  resp_t                 push_data;
  logic                  push_valid;
  resp_t                 fifo_out;
  logic                  fifo_in_ready;
  logic                  unused_fifo_in_ready;
  logic                  unused_resp_bits;

  assign accept  = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign ready_o = (occ < OCC_W'(OUT_DEPTH));

  // Read-first: the word is sampled before the same-edge write lands.
  assign rd_word = ram[addr];

`ifdef CPRV_RAM_WSTRB_EN
  // Expand byte strobes to a bit mask.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end
`else
  logic unused_wstrb;
  assign wmask        = '1;
  assign unused_wstrb = ^wstrb;
`endif

  // RAM write commits at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && w_en) begin
      ram[addr] <= (rd_word & ~wmask) | (wdata & wmask);
    end
  end

  // Package the sampled word as a response, zero-extended to the struct width.
  always_comb begin
    acc_resp = '0;
    acc_resp.rdata[DATA_WIDTH-1:0] = rd_word;
    acc_resp.resp_we = w_en;
  end

  // The first pipeline register is the RAM sample at the accept edge; with
  // LAT == 1 the sample goes straight into the FIFO at that edge.
  generate
    if (LAT == 1) begin : g_no_pipe
      assign push_valid = accept;
      assign push_data  = acc_resp;
    end else begin : g_pipe
      logic  pv [LAT-1];
      resp_t pd [LAT-1];

      // Shift responses down the latency pipeline; reset drops in-flight ones.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT - 1; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
          end
        end else begin
          pv[0] <= accept;
          pd[0] <= acc_resp;
          for (int i = 1; i < LAT - 1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign push_valid = pv[LAT-2];
      assign push_data  = pd[LAT-2];
    end
  endgenerate

  // Credit counter covers in-flight plus buffered responses, so the FIFO
  // always has room for every push and never needs to back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  cprv_resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (OUT_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (push_data),
    .out_valid (valid_o),
    .out_ready (ready_i),
    .out_data  (fifo_out)
  );

  assign rdata   = fifo_out.rdata[DATA_WIDTH-1:0];
  assign resp_we = fifo_out.resp_we;

  // FIFO space is guaranteed by the credit counter; bits above DATA_WIDTH
  // are always zero.
  assign unused_fifo_in_ready = fifo_in_ready;
  assign unused_resp_bits     = ^fifo_out.rdata;

endmodule

// File: tb/tb_cprv_ram_1p_pipe.sv
// Directed bench for cprv_ram_1p_pipe with RD_LATENCY=3, OUT_DEPTH=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cprv_ram_1p_pipe;

  localparam int AW  = 7;
  localparam int DW  = 64;
  localparam int LAT = 3;
  localparam int OD  = LAT + 1;

`ifdef CPRV_RAM_WSTRB_EN
  localparam logic [DW-1:0] WSTRB_EXP = 64'hFFFF_FFFF_0000_0000;
`else
  localparam logic [DW-1:0] WSTRB_EXP = 64'h0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic            w_en = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [DW-1:0]   rdata;
  logic            resp_we;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard: expected responses in acceptance order.
  logic [DW-1:0] exp_q[$];
  logic          exp_we_q[$];
  logic          exp_chk_q[$];

  // Reference memory with a known-contents flag per word.
  logic [DW-1:0] model [2**AW];
  logic          model_ok [2**AW];

  logic [AW-1:0] rd_addrs [3];

  cprv_ram_1p_pipe #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (LAT),
    .OUT_DEPTH  (OD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .w_en    (w_en),
    .addr    (addr),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .rdata   (rdata),
    .resp_we (resp_we)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Record the expected response for a request accepted this cycle.
  task automatic expect_access(input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    logic [DW-1:0] m;
    exp_q.push_back(model[a]);
    exp_we_q.push_back(we);
    exp_chk_q.push_back(model_ok[a]);
    if (we) begin
`ifdef CPRV_RAM_WSTRB_EN
      for (int b = 0; b < DW/8; b++) m[b*8 +: 8] = {8{s[b]}};
`else
      m = '1;
`endif
      model[a]    = (model[a] & ~m) | (d & m);
      model_ok[a] = model_ok[a] | (m == '1);
    end
  endtask

  // Score any response handshake happening at the coming edge, then advance.
  task automatic tick();
    logic [DW-1:0] e;
    logic          we;
    logic          c;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", valid_o, 1'b0);
      end else begin
        e  = exp_q.pop_front();
        we = exp_we_q.pop_front();
        c  = exp_chk_q.pop_front();
        check("resp_we", resp_we, we);
        if (c) check("resp_rdata", rdata, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one request and hold it until accepted (bounded).
  task automatic issue(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    logic acc;
    int   n;
    n = 0;
    valid_i = 1'b1;
    w_en    = we;
    addr    = a;
    wdata   = d;
    wstrb   = s;
    do begin
      acc = ready_o;
      if (acc) expect_access(we, a, d, s);
      tick();
      n++;
    end while (!acc && n < 50);
    check("issue_accept", acc, 1'b1);
    valid_i = 1'b0;
  endtask

  // Consume every outstanding response (bounded).
  task automatic drain();
    int n;
    n = 0;
    ready_i = 1'b1;
    while ((exp_q.size() != 0 || valid_o) && n < 100) begin
      tick();
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", valid_o, 1'b0);
  endtask

  // Read one address on an idle pipe and compare against a hand value.
  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] e,
                            input string tag, output int lat);
    int n;
    ready_i = 1'b1;
    issue(1'b0, a, '0, '0);
    n = 1;
    while (!valid_o && n < 20) begin
      tick();
      n++;
    end
    check(tag, rdata, e);
    check({tag, "_we"}, resp_we, 1'b0);
    lat = n;
    drain();
  endtask

  initial begin
    int lat;
    int acc_cnt;
    int drops;
    int n;
    for (int i = 0; i < 2**AW; i++) begin
      model[i]    = '0;
      model_ok[i] = 1'b0;
    end
    rd_addrs[0] = 7'd5;
    rd_addrs[1] = 7'd3;
    rd_addrs[2] = 7'd9;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_o", valid_o, 1'b0);
    check("reset_rdata", rdata, 64'h0);
    check("reset_resp_we", resp_we, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready_o", ready_o, 1'b1);

    // Write then read: valid_o shows up in cycle LAT+1 counting the accept cycle.
    ready_i = 1'b1;
    issue(1'b1, 7'd5, 64'h1122334455667788, '1);
    drain();
    read_check(7'd5, 64'h1122334455667788, "read_after_write", lat);
    check("read_latency", lat, LAT);

    // Back-to-back write then read of the same word.
    issue(1'b1, 7'd3, 64'h3333, '1);
    drain();
    issue(1'b1, 7'd3, 64'hAA, '1);
    issue(1'b0, 7'd3, '0, '0);
    drain();
    read_check(7'd3, 64'hAA, "b2b_reread", lat);

    // Byte strobes: merge or full overwrite depending on the build.
    issue(1'b1, 7'd9, 64'hFFFF_FFFF_FFFF_FFFF, '1);
    issue(1'b1, 7'd9, 64'h0, 8'h0F);
    drain();
    read_check(7'd9, WSTRB_EXP, "wstrb_result", lat);

    // Back-pressure: 8 attempts with ready_i low, only OD are accepted.
    ready_i = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      w_en    = 1'b0;
      addr    = rd_addrs[i % 3];
      if (ready_o) begin
        expect_access(1'b0, addr, '0, '0);
        acc_cnt++;
      end
      tick();
    end
    valid_i = 1'b0;
    check("burst_accepts", acc_cnt, OD);
    check("burst_ready_low", ready_o, 1'b0);
    check("burst_valid_o", valid_o, 1'b1);
    ready_i = 1'b1;
    check("ready_before_pop", ready_o, 1'b0);
    tick();
    check("ready_after_pop", ready_o, 1'b1);
    drain();

    // Stream of 100 reads: no ready_o drop, last response consumed at tick 100+LAT.
    ready_i = 1'b1;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      valid_i = 1'b1;
      w_en    = 1'b0;
      addr    = rd_addrs[$urandom_range(0, 2)];
      if (!ready_o) drops++;
      else expect_access(1'b0, addr, '0, '0);
      tick();
    end
    valid_i = 1'b0;
    n = 100;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("stream_ready_drops", drops, 0);
    check("stream_cycles", n, 100 + LAT);
    drain();

    // Reset with three responses buffered.
    ready_i = 1'b0;
    issue(1'b0, 7'd5, '0, '0);
    issue(1'b0, 7'd3, '0, '0);
    issue(1'b0, 7'd9, '0, '0);
    repeat (LAT) tick();
    check("buffered_valid_o", valid_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid_o", valid_o, 1'b0);
    check("mid_reset_rdata", rdata, 64'h0);
    check("mid_reset_resp_we", resp_we, 1'b0);
    exp_q.delete();
    exp_we_q.delete();
    exp_chk_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_ready_o", ready_o, 1'b1);
    check("post_reset_valid_o", valid_o, 1'b0);
    read_check(7'd5, 64'h1122334455667788, "reset_keeps_addr5", lat);
    read_check(7'd3, 64'hAA, "reset_keeps_addr3", lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cprv_ram_1p_pipe.md
CPRV_RAM_1P_PIPE -- requirements
Module: cprv_ram_1p_pipe

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: word address width; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 64: word width; SHALL be a multiple of 8.
REQ-003 Parameter RD_LATENCY, default 1: request-accept to response-FIFO-write latency in cycles; legal range 1..4.
REQ-004 Parameter OUT_DEPTH, default RD_LATENCY+1: response FIFO entries; SHALL be >= RD_LATENCY+1.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 valid_i  in  1  request valid.
REQ-009 ready_o  out  1  request accepted when valid_i & ready_o.
REQ-010 w_en  in  1  request is a write.
REQ-011 addr  in  ADDR_WIDTH  word address.
REQ-012 wdata  in  DATA_WIDTH  write data.
REQ-013 wstrb  in  DATA_WIDTH/8  byte write enables (used only under CPRV_RAM_WSTRB_EN).
REQ-014 valid_o  out  1  response valid.
REQ-015 ready_i  in  1  response consumed when valid_o & ready_i.
REQ-016 rdata  out  DATA_WIDTH  read data (read-first contents for writes).
REQ-017 resp_we  out  1  response belongs to a write request.

Function
REQ-018 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-019 Credit counter occ (0..OUT_DEPTH): +1 on accept, -1 on response handshake, both in the same cycle leaves it unchanged.
REQ-020 ready_o SHALL be (occ < OUT_DEPTH), from registered state only; no combinational path from ready_i.
REQ-021 valid_i/w_en/addr/wdata/wstrb with ready_o low SHALL cause no RAM access or state change.
REQ-022 RAM array is sampled at the accept edge; the write commits at that edge.
REQ-023 Read-first: rdata for a write response SHALL be the word's contents before that write.
REQ-024 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-025 Read data SHALL pass through RD_LATENCY-1 extra pipeline stages and enter the response FIFO exactly RD_LATENCY cycles after accept.
REQ-026 The response FIFO SHALL never overflow; the credit rule guarantees space.
REQ-027 valid_o SHALL be high iff the FIFO is non-empty; rdata/resp_we SHALL hold stable while valid_o & ~ready_i.
REQ-028 With ready_i held high and OUT_DEPTH >= RD_LATENCY+1, one request per cycle SHALL be sustained.
REQ-029 Simultaneous FIFO push and pop at any occupancy, including full, SHALL be lossless.
REQ-030 FIFO read/write pointers SHALL wrap modulo OUT_DEPTH; OUT_DEPTH need not be a power of two.

Reset
REQ-031 While rst_n low: occ=0, pipeline valids=0, FIFO empty, valid_o=0, ready_o=1 after release.
REQ-032 Reset mid-operation SHALL discard all in-flight and buffered responses; RAM contents are not cleared.
REQ-033 rdata and resp_we SHALL be 0 on reset.

Configuration
REQ-034 Macro CPRV_RAM_WSTRB_EN defined: a write updates only bytes whose wstrb bit is 1; other bytes keep their values.
REQ-035 CPRV_RAM_WSTRB_EN undefined: wstrb SHALL be ignored; writes update the full word.

Structure
REQ-036 Package cprv_ram_pkg SHALL hold RD_LATENCY_MAX=4 and the response struct typedef {rdata, resp_we}.
REQ-037 Sub-module cprv_resp_fifo (parametrised width/depth, valid/ready both sides) SHALL implement the response FIFO.
REQ-038 The RAM array, latency pipeline and credit counter SHALL live in cprv_ram_1p_pipe.

Verification
REQ-039 Write 0x1122334455667788 to addr 5, then read addr 5 -> read response 0x1122334455667788, resp_we=0, RD_LATENCY+1 cycles after read accept.
REQ-040 RD_LATENCY=3, ready_i=0, issue 8 reads -> exactly 4 accepted, ready_o=0; then ready_i=1 -> 4 responses in order, ready_o returns high the cycle after the first pop.
REQ-041 CPRV_RAM_WSTRB_EN, word 0xFFFF_FFFF_FFFF_FFFF, write 0 with wstrb=0x0F -> read returns 0xFFFF_FFFF_0000_0000; without macro -> 0.
REQ-042 Back-to-back write 0xAA to addr 3 then read addr 3 -> write response rdata = old value, read response = 0xAA.
REQ-043 Stream of 100 reads with ready_i=1 -> 100 responses in 100+RD_LATENCY cycles, no ready_o drop.
REQ-044 Assert rst_n low with 3 responses buffered -> valid_o=0 immediately, ready_o=1 after release, RAM data preserved on re-read.
